// File: rtl/bcd_game_pkg.sv
// Shared definitions for the math-game answer entry path.
package bcd_game_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2,
        LOCK   = 2'd3
    } state_t;

    localparam int unsigned BCD_W   = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    // Next BCD value of one digit, wrapping 9 back to 0 without carry.
    function automatic logic [BCD_W-1:0] bcd_next(input logic [BCD_W-1:0] d);
        return (d >= BCD_MAX) ? '0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit register: clear dominates, increment wraps 9 -> 0.
module bcd_digit_cell
    import bcd_game_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [BCD_W-1:0] digit
);

    // Digit storage with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit <= '0;
        end else if (clear) begin
            digit <= '0;
        end else if (inc) begin
            digit <= bcd_next(digit);
        end
    end

endmodule

// File: rtl/bcd_answer_entry.sv
// Builds a multi-digit BCD answer from button pulses and commits it on submit.
module bcd_answer_entry
    import bcd_game_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 2,
    parameter int unsigned SEL_W      = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        inc_pulse,
    input  logic                        sel_pulse,
    input  logic                        submit_pulse,
    output logic [BCD_W*NUM_DIGITS-1:0] entry_bcd,
    output logic [SEL_W-1:0]            digit_sel,
    output logic                        entry_active,
    output logic [BCD_W*NUM_DIGITS-1:0] answer_bcd,
    output logic                        answer_valid
);

    localparam logic [SEL_W-1:0] SEL_TOP = SEL_W'(NUM_DIGITS - 1);

    state_t state;
    state_t next_state;
    logic   edit_live;
    logic   do_submit;
    logic   do_sel;
    logic   do_inc;
    logic   clear;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and one-hot pulse decode; enable loss beats every pulse,
    // then submit > sel > inc with lower-priority pulses dropped.
    always_comb begin
        next_state = state;
        edit_live  = 1'b0;
        do_submit  = 1'b0;
        do_sel     = 1'b0;
        do_inc     = 1'b0;
        case (state)
            IDLE: begin
                if (enable) next_state = EDIT;
            end
            EDIT: begin
                if (!enable) begin
                    next_state = IDLE;
                end else begin
                    edit_live = 1'b1;
                    do_submit = submit_pulse;
                    do_sel    = !submit_pulse && sel_pulse;
                    do_inc    = !submit_pulse && !sel_pulse && inc_pulse;
                    if (submit_pulse) next_state = COMMIT;
                end
            end
            COMMIT: next_state = LOCK;
            LOCK: begin
                if (!enable) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        // Clearing on the edge that enters IDLE (and while staying there)
        // means the entry is already zero the first cycle IDLE is visible.
        clear = (next_state == IDLE);
    end

    // Digit selection, answer latch and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit_sel    <= SEL_TOP;
            answer_bcd   <= '0;
            answer_valid <= 1'b0;
            entry_active <= 1'b0;
        end else begin
            answer_valid <= do_submit;
            entry_active <= (next_state == EDIT);
            if (do_submit) answer_bcd <= entry_bcd;
            if (clear) begin
                digit_sel <= SEL_TOP;
            end else if (do_sel) begin
                digit_sel <= (digit_sel == '0) ? SEL_TOP : digit_sel - 1'b1;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
            bcd_digit_cell u_cell (
                .clk   (clk),
                .rst   (rst),
                .clear (clear),
                .inc   (edit_live && do_inc && (digit_sel == SEL_W'(g))),
                .digit (entry_bcd[g*BCD_W +: BCD_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_bcd_answer_entry.sv
// Self-checking bench for bcd_answer_entry with a behavioural reference model.
module tb_bcd_answer_entry;

    localparam int N = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       inc_pulse;
    logic       sel_pulse;
    logic       submit_pulse;
    logic [7:0] entry_bcd;
    logic [0:0] digit_sel;
    logic       entry_active;
    logic [7:0] answer_bcd;
    logic       answer_valid;

    int tests = 0;
    int fails = 0;

    // Reference model: plain digit array plus "what is the player allowed to do" flags.
    int md[N];
    int msel;
    int m_ans;
    bit m_editing, m_committing, m_locked, m_valid;

    always #5 clk = ~clk;

    bcd_answer_entry #(.NUM_DIGITS(2), .SEL_W(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .inc_pulse    (inc_pulse),
        .sel_pulse    (sel_pulse),
        .submit_pulse (submit_pulse),
        .entry_bcd    (entry_bcd),
        .digit_sel    (digit_sel),
        .entry_active (entry_active),
        .answer_bcd   (answer_bcd),
        .answer_valid (answer_valid)
    );

    function automatic int m_entry();
        return md[1] * 16 + md[0];
    endfunction

    task automatic model_reset();
        md[0] = 0; md[1] = 0; msel = N - 1; m_ans = 0;
        m_editing = 0; m_committing = 0; m_locked = 0; m_valid = 0;
    endtask

    task automatic model_edge(input bit en, input bit inc, input bit sel, input bit sub);
        m_valid = 0;
        if (m_editing) begin
            if (!en) begin
                m_editing = 0; md[0] = 0; md[1] = 0; msel = N - 1;
            end else if (sub) begin
                m_ans = m_entry(); m_valid = 1; m_editing = 0; m_committing = 1;
            end else if (sel) begin
                msel = (msel + N - 1) % N;
            end else if (inc) begin
                md[msel] = (md[msel] + 1) % 10;
            end
        end else if (m_committing) begin
            m_committing = 0; m_locked = 1;
        end else if (m_locked) begin
            if (!en) begin
                m_locked = 0; md[0] = 0; md[1] = 0; msel = N - 1;
            end
        end else begin
            md[0] = 0; md[1] = 0; msel = N - 1;
            if (en) m_editing = 1;
        end
    endtask

    // One clock: drive at negedge, advance model at posedge, return #1 after it.
    task automatic step(input bit en, input bit inc, input bit sel, input bit sub);
        @(negedge clk);
        enable = en; inc_pulse = inc; sel_pulse = sel; submit_pulse = sub;
        @(posedge clk);
        model_edge(en, inc, sel, sub);
        #1;
    endtask

    // From any state, go back to IDLE and enter EDIT with value v, leaving digit_sel = 1.
    task automatic enter_with(input int v);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (v / 16) step(1, 1, 0, 0);
        step(1, 0, 1, 0);
        repeat (v % 16) step(1, 1, 0, 0);
        step(1, 0, 1, 0);
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 0; inc_pulse = 0; sel_pulse = 0; submit_pulse = 0;
        model_reset();
        @(posedge clk); #1;
        tests++;
        if ({entry_bcd, answer_bcd, entry_active, answer_valid, digit_sel} !== {8'h00, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset_state: got entry=%h ans=%h act=%b val=%b sel=%b expected 00 00 0 0 1",
                     entry_bcd, answer_bcd, entry_active, answer_valid, digit_sel);
        end
        @(negedge clk); rst = 1'b1;
        enter_with(8'h37);
        tests++;
        if (entry_bcd !== 8'h37 || entry_active !== 1'b1) begin
            fails++;
            $display("FAIL reset_build37: got entry=%h act=%b expected 37 1", entry_bcd, entry_active);
        end
        #2 rst = 1'b0;
        model_reset();
        #1;
        tests++;
        if ({entry_bcd, answer_bcd, entry_active, answer_valid, digit_sel} !== {8'h00, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset_async: got entry=%h ans=%h act=%b val=%b sel=%b expected 00 00 0 0 1",
                     entry_bcd, answer_bcd, entry_active, answer_valid, digit_sel);
        end
        @(negedge clk); rst = 1'b1;
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        step(0, 1, 0, 1);
        tests++;
        if (entry_bcd !== 8'h00 || digit_sel !== 1'b1 || entry_active !== 1'b0 || answer_valid !== 1'b0) begin
            fails++;
            $display("FAIL idle_ignores: got entry=%h sel=%b act=%b val=%b expected 00 1 0 0",
                     entry_bcd, digit_sel, entry_active, answer_valid);
        end
    endtask

    task automatic test_entry_wrap();
        step(1, 0, 0, 0);
        repeat (10) step(1, 1, 0, 0);
        tests++;
        if (entry_bcd !== 8'h00) begin
            fails++;
            $display("FAIL wrap_no_carry: got %h expected 00", entry_bcd);
        end
        step(1, 0, 1, 0);
        repeat (3) step(1, 1, 0, 0);
        tests++;
        if (entry_bcd !== 8'h03 || digit_sel !== 1'b0) begin
            fails++;
            $display("FAIL entry_03: got entry=%h sel=%b expected 03 0", entry_bcd, digit_sel);
        end
        step(1, 0, 1, 0);
        tests++;
        if (digit_sel !== 1'b1) begin
            fails++;
            $display("FAIL sel_wrap: got %b expected 1", digit_sel);
        end
    endtask

    task automatic test_commit();
        int strobes;
        enter_with(8'h42);
        step(1, 0, 0, 1);
        tests++;
        if (answer_valid !== 1'b1 || answer_bcd !== 8'h42 || entry_active !== 1'b0) begin
            fails++;
            $display("FAIL commit_strobe: got val=%b ans=%h act=%b expected 1 42 0",
                     answer_valid, answer_bcd, entry_active);
        end
        strobes = 0;
        repeat (4) begin
            step(1, 1, 0, 1);
            if (answer_valid === 1'b1) strobes++;
        end
        tests++;
        if (strobes != 0 || answer_bcd !== 8'h42 || entry_bcd !== 8'h42) begin
            fails++;
            $display("FAIL lock_hold: got strobes=%0d ans=%h entry=%h expected 0 42 42",
                     strobes, answer_bcd, entry_bcd);
        end
    endtask

    task automatic test_priority();
        enter_with(8'h15);
        step(1, 1, 0, 1);
        tests++;
        if (answer_bcd !== 8'h15 || answer_valid !== 1'b1 || entry_bcd !== 8'h15) begin
            fails++;
            $display("FAIL prio_submit_inc: got ans=%h val=%b entry=%h expected 15 1 15",
                     answer_bcd, answer_valid, entry_bcd);
        end
        enter_with(8'h15);
        step(1, 1, 1, 0);
        tests++;
        if (digit_sel !== 1'b0 || entry_bcd !== 8'h15) begin
            fails++;
            $display("FAIL prio_sel_inc: got sel=%b entry=%h expected 0 15", digit_sel, entry_bcd);
        end
    endtask

    task automatic test_abort();
        enter_with(8'h88);
        step(0, 0, 0, 0);
        tests++;
        if (entry_bcd !== 8'h00 || answer_valid !== 1'b0 || answer_bcd !== 8'h15 || entry_active !== 1'b0) begin
            fails++;
            $display("FAIL abort: got entry=%h val=%b ans=%h act=%b expected 00 0 15 0",
                     entry_bcd, answer_valid, answer_bcd, entry_active);
        end
    endtask

    task automatic test_back_to_back();
        int strobes;
        enter_with(8'h12);
        step(1, 0, 0, 1);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        tests++;
        if (entry_bcd !== 8'h00 || digit_sel !== 1'b1) begin
            fails++;
            $display("FAIL relock_idle: got entry=%h sel=%b expected 00 1", entry_bcd, digit_sel);
        end
        step(1, 0, 0, 0);
        tests++;
        if (entry_active !== 1'b1 || entry_bcd !== 8'h00 || digit_sel !== 1'b1) begin
            fails++;
            $display("FAIL relock_edit: got act=%b entry=%h sel=%b expected 1 00 1",
                     entry_active, entry_bcd, digit_sel);
        end
        repeat (9) step(1, 1, 0, 0);
        step(1, 0, 1, 0);
        repeat (9) step(1, 1, 0, 0);
        strobes = 0;
        step(1, 0, 0, 1);
        if (answer_valid === 1'b1) strobes++;
        repeat (3) begin
            step(1, 0, 0, 1);
            if (answer_valid === 1'b1) strobes++;
        end
        tests++;
        if (strobes != 1 || answer_bcd !== 8'h99) begin
            fails++;
            $display("FAIL second_commit: got strobes=%0d ans=%h expected 1 99", strobes, answer_bcd);
        end
    endtask

    task automatic test_random();
        bit en, inc, sel, sub, prev_valid;
        prev_valid = 0;
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(0, 15) != 0);
            inc = ($urandom_range(0, 1) == 1);
            sel = ($urandom_range(0, 3) == 0);
            sub = ($urandom_range(0, 11) == 0);
            step(en, inc, sel, sub);
            tests++;
            if (entry_bcd !== 8'(m_entry()) || digit_sel !== 1'(msel) || entry_active !== m_editing ||
                answer_bcd !== 8'(m_ans) || answer_valid !== m_valid) begin
                fails++;
                $display("FAIL random[%0d]: got entry=%h sel=%b act=%b ans=%h val=%b expected %h %0d %b %h %b",
                         i, entry_bcd, digit_sel, entry_active, answer_bcd, answer_valid,
                         m_entry(), msel, m_editing, m_ans, m_valid);
            end
            if (prev_valid && answer_valid) begin
                fails++;
                $display("FAIL valid_double[%0d]: got 1 on consecutive cycles expected 0", i);
            end
            prev_valid = answer_valid;
        end
    endtask

    initial begin
        test_reset();
        test_entry_wrap();
        test_commit();
        test_priority();
        test_abort();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_answer_entry.md
Name: bcd_answer_entry

Overview:
- Consumes the one-cycle button pulses from the per-button shaper stages and builds a multi-digit BCD answer for the math game.
- Player actions: increment the selected digit, move to the next digit, submit.
- On submit, presents the latched answer with a one-cycle valid strobe to the game controller.
- Then locks out further input until the controller drops enable.

Parameters:
- NUM_DIGITS, 2, number of BCD digits in the answer (1..4).
- SEL_W, 1, width of digit_sel; must equal max(1, clog2(NUM_DIGITS)).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- enable  in  1  game controller permits entry (level)
- inc_pulse  in  1  one-cycle pulse: increment selected digit
- sel_pulse  in  1  one-cycle pulse: move selection to next lower digit
- submit_pulse  in  1  one-cycle pulse: commit current entry
- entry_bcd  out  4*NUM_DIGITS  live entry, digit NUM_DIGITS-1 in the MS nibble
- digit_sel  out  SEL_W  index of the digit currently being edited
- entry_active  out  1  high while in EDIT
- answer_bcd  out  4*NUM_DIGITS  last committed answer, held
- answer_valid  out  1  one-cycle strobe, answer_bcd newly committed

Behaviour:

Outputs and reset:
- All outputs are registered.
- rst low asynchronously forces:
  - state = IDLE
  - entry_bcd = 0, answer_bcd = 0
  - digit_sel = NUM_DIGITS-1
  - entry_active = 0, answer_valid = 0
- Reset released mid-operation: resume from IDLE; no answer_valid is emitted.

State machine:
- IDLE: entry_bcd held at 0, digit_sel = NUM_DIGITS-1. enable=1 -> EDIT on the next edge. Pulses are ignored.
- EDIT: entry_active=1. Per edge, act on at most one pulse, priority submit > sel > inc. Lower-priority simultaneous pulses are dropped, not queued.
  - enable=0 (checked before any pulse) -> IDLE; entry cleared; no answer_valid.
  - submit_pulse -> COMMIT; answer_bcd <= entry_bcd on the same edge.
  - sel_pulse -> digit_sel decrements; 0 wraps to NUM_DIGITS-1.
  - inc_pulse -> selected nibble increments; 9 wraps to 0; no carry into neighbours; other nibbles unchanged.
- COMMIT: exactly one cycle. answer_valid=1, entry_active=0. Unconditionally -> LOCK. Pulses are ignored.
- LOCK: answer_valid=0. entry_bcd and answer_bcd are held; pulses are ignored. enable=0 -> IDLE, where entry is cleared and digit_sel is reset.
- Unreachable state encodings -> IDLE on the next edge.

Latency:
- Pulse sampled at edge n -> entry_bcd / digit_sel updated after edge n.
- submit at edge n -> answer_valid high for the cycle following edge n, low after edge n+1.

Invariants:
- Every entry_bcd nibble is always in 0..9.
- answer_valid is never high for two consecutive cycles.
- answer_bcd changes only on a commit or on reset.

NUM_DIGITS=1: sel_pulse leaves digit_sel at 0, but still consumes priority over inc.

Decomposition:
- Shared game header/package (bcd_game_pkg) holds:
  - state encodings IDLE=0, EDIT=1, COMMIT=2, LOCK=3
  - BCD_MAX=9, BCD_W=4
- Natural sub-module: bcd_digit_cell, one 4-bit digit register per digit.
  - Inputs: clk, rst, clear, inc.
  - Behaviour: clear has priority; inc wraps 9->0.
  - Instantiated NUM_DIGITS times via generate.
  - Each cell's inc = EDIT & inc_pulse & ~sel_pulse & ~submit_pulse & (digit_sel == index).
- FSM, digit_sel and the answer register stay in the top module.

Test Plan:
- Reset/idle: rst low mid-EDIT with entry 0x37 -> all outputs 0 immediately, digit_sel=1; after release with enable=0, pulses leave entry_bcd=0x00.
- Entry and wrap: enable=1, 10 inc_pulses on digit 1, then sel, 3 inc_pulses -> entry_bcd=0x03 (digit 1 wrapped 9->0, no carry); another sel -> digit_sel=1.
- Commit: entry 0x42, submit at edge n -> answer_bcd=0x42 and answer_valid=1 for exactly one cycle; further inc/submit in LOCK leave entry and answer unchanged and give no strobe.
- Priority: submit+inc same cycle at entry 0x15 -> answer_bcd=0x15 (inc dropped); sel+inc same cycle -> digit_sel moves, entry unchanged.
- Abort: enable drops in EDIT at entry 0x88 -> IDLE, entry_bcd=0x00, answer_valid stays 0, answer_bcd keeps the prior value.
- Relock cycle: after LOCK, enable 0 then 1 -> EDIT with entry 0x00 and digit_sel=1; a second commit of 0x99 strobes once.
